// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote at mid-bit,
// small receive FIFO on a valid/ready byte stream, framing-error and overrun flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, counters held at 0, waiting for rxs low
// S_START | start bit; majority high at decision means a glitch -> S_IDLE
// S_DATA  | 8 data bits, LSB first, shifted in at each decision
// S_STOP  | stop bit; decide at tick 9 and leave early to catch next start
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_TICK = 54,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       err_clr_i,
  output logic       busy_o
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic tick, maj, decide, bit_end;
  logic pop, full, empty, push_ok, drop;

  assign tick    = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
  assign maj     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  assign decide  = tick && (samp_q == 4'd9);
  assign bit_end = tick && (samp_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    samp_d      = tick ? samp_q + 4'd1 : samp_q;
    bit_idx_d   = bit_idx_q;
    s7_d        = (tick && samp_q == 4'd7) ? rxs_q : s7_q;
    s8_d        = (tick && samp_q == 4'd8) ? rxs_q : s8_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Counters restart here so bit phase lines up with the falling edge.
        tick_cnt_d = '0;
        samp_d     = 4'd0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (maj) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: extra pointer bit separates full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rx_valid_o && rx_ready_i;
  assign push_ok = push_q && (!full || pop);
  assign drop    = push_q && full && !pop;

  always_comb begin
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = err_clr_i ? 1'b0 : (overrun_q | drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tick_cnt_q  <= '0;
      samp_q      <= 4'd0;
      bit_idx_q   <= 3'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= 8'd0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_i;
      rxs_q       <= rx_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign rx_valid_o  = !empty;
  assign rx_data_o   = empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + random bench for uart_rx; a byte-level queue model predicts what
// the receive stream, overrun flag and framing-error count should be.
module tb_uart_rx;
  localparam int CPT   = 2;
  localparam int DEPTH = 4;
  localparam int BIT_CYC = 16 * CPT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int valid_cycles = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] fifo_mdl[$];
  logic       mdl_ovr = 1'b0;

  uart_rx #(.CLKS_PER_TICK(CPT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .frame_err_o(frame_err), .overrun_o(overrun), .err_clr_i(err_clr),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so values seen here are what the DUT acts on next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (rx_valid) valid_cycles++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (rx_ready) exp_q.push_back(b);
    else if (fifo_mdl.size() < DEPTH) fifo_mdl.push_back(b);
    else mdl_ovr = 1'b1;
  endtask

  // One 8N1 frame; glitch_at inverts a single cycle, rst_at asserts reset and aborts.
  task automatic send(input logic [7:0] b, input logic stop, input int glitch_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10 * BIT_CYC; j++) begin
      if (j == rst_at) begin
        rst_n = 1'b0;
        rx = 1'b1;
        return;
      end
      rx = fr[j / BIT_CYC] ^ (j == glitch_at);
      step(1);
    end
    if (stop) model_byte(b);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;

    // Reset values
    rst_n = 1'b0;
    step(3);
    chk("rst_valid", 32'(rx_valid), 32'(0));
    chk("rst_data", 32'(rx_data), 32'(0));
    chk("rst_ferr", 32'(frame_err), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    step(5);

    // Single byte with consumer ready
    rx_ready = 1'b1;
    valid_cycles = 0;
    send(8'hA5, 1'b1, -1, -1);
    step(20);
    chk("a5_busy", 32'(busy), 32'(0));
    chk("a5_valid_cycles", 32'(valid_cycles), 32'(1));
    chk("a5_ferr", 32'(fe_cnt), 32'(0));
    chk("a5_ovr", 32'(overrun), 32'(mdl_ovr));
    check_stream("a5");

    // Short low glitch on idle line
    rx = 1'b0;
    step(10);
    rx = 1'b1;
    step(60);
    chk("glitch_busy", 32'(busy), 32'(0));
    chk("glitch_ferr", 32'(fe_cnt), 32'(0));
    check_stream("glitch");

    // Low stop bit, line held low, then released
    send(8'h3C, 1'b0, -1, -1);
    step(50);
    chk("brk_busy_a", 32'(busy), 32'(1));
    step(50);
    chk("brk_busy_b", 32'(busy), 32'(1));
    chk("brk_ferr", 32'(fe_cnt), 32'(1));
    rx = 1'b1;
    step(10);
    chk("brk_busy_end", 32'(busy), 32'(0));
    chk("brk_ferr_once", 32'(fe_cnt), 32'(1));
    check_stream("brk");
    send(8'h81, 1'b1, -1, -1);
    step(20);
    check_stream("after_brk");

    // Random bytes with random idle gaps, including back-to-back frames
    repeat (6) begin
      rb = 8'($urandom);
      send(rb, 1'b1, -1, -1);
      step($urandom_range(0, 5));
    end
    step(20);
    check_stream("rand");

    // Overrun: five frames into a four-entry FIFO
    rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, -1, -1);
    step(5);
    chk("ovr_set", 32'(overrun), 32'(mdl_ovr));
    chk("ovr_valid", 32'(rx_valid), 32'(1));
    chk("ovr_head", 32'(rx_data), 32'(fifo_mdl[0]));
    rx_ready = 1'b1;
    foreach (fifo_mdl[i]) exp_q.push_back(fifo_mdl[i]);
    fifo_mdl.delete();
    step(10);
    check_stream("drain");
    chk("ovr_sticky", 32'(overrun), 32'(mdl_ovr));
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    mdl_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'(mdl_ovr));
    chk("drain_empty", 32'(rx_valid), 32'(0));

    // One-cycle high glitch on the middle sample of data bit 3
    send(8'h00, 1'b1, 4 * BIT_CYC + 18, -1);
    step(20);
    chk("vote_ferr", 32'(fe_cnt), 32'(1));
    check_stream("vote");

    // Reset mid-frame with bytes queued
    rx_ready = 1'b0;
    send(8'($urandom), 1'b1, -1, -1);
    send(8'($urandom), 1'b1, -1, -1);
    step(3);
    chk("pre_rst_valid", 32'(rx_valid), 32'(1));
    send(8'hFF, 1'b1, -1, 5 * BIT_CYC + 10);
    #1;
    fifo_mdl.delete();
    mdl_ovr = 1'b0;
    chk("mid_rst_valid", 32'(rx_valid), 32'(0));
    chk("mid_rst_data", 32'(rx_data), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ovr", 32'(overrun), 32'(mdl_ovr));
    chk("mid_rst_ferr", 32'(frame_err), 32'(0));
    step(3);
    rst_n = 1'b1;
    step(10);
    rx_ready = 1'b1;
    send(8'h5A, 1'b1, -1, -1);
    step(20);
    check_stream("post_rst");
    chk("post_rst_busy", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
